// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer sharing one synchronous-read data
// memory port between the CPU MEM stage (port A) and the loader (port B).
// Accepted accesses are registered onto the memory port one cycle after
// acceptance. Read data is steered back to the port that issued the load
// using a two-stage {valid, owner} tag pipeline that matches the memory
// read latency.
module dmem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  // port A: CPU MEM stage
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          cpu_stall,
  // port B: debug / program loader
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  // shared memory port
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  logic          last_winner_q, last_winner_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          tag1_valid_q, tag1_valid_d;
  logic          tag1_owner_q, tag1_owner_d;
  logic          tag2_valid_q, tag2_valid_d;
  logic          tag2_owner_q, tag2_owner_d;

  logic          accept;
  logic          sel_b;
  logic          win_we;

  // Grant: a lone requester wins; on contention the port that did not win
  // last time wins. Nothing is granted while reset is held.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset) begin
      if (a_req && (!b_req || last_winner_q == OWNER_B)) begin
        a_ready = 1'b1;
      end else if (b_req) begin
        b_ready = 1'b1;
      end
    end
  end

  assign accept    = a_ready | b_ready;
  assign sel_b     = b_ready;
  assign win_we    = sel_b ? b_we : a_we;
  assign cpu_stall = a_req & ~a_ready;

  // Next state: issue register, round-robin pointer and read tag pipeline.
  always_comb begin
    last_winner_d = last_winner_q;
    m_en_d        = 1'b0;
    m_we_d        = 1'b0;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    tag1_valid_d  = 1'b0;
    tag1_owner_d  = tag1_owner_q;
    tag2_valid_d  = tag1_valid_q;
    tag2_owner_d  = tag1_owner_q;
    if (accept) begin
      last_winner_d = sel_b;
      m_en_d        = 1'b1;
      m_we_d        = win_we;
      m_addr_d      = sel_b ? b_addr : a_addr;
      m_wdata_d     = sel_b ? b_wdata : a_wdata;
      tag1_valid_d  = ~win_we;
      tag1_owner_d  = sel_b;
    end
  end

  // State registers; reset drops any in-flight read and the issued access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner_q <= OWNER_B;
      m_en_q        <= 1'b0;
      m_we_q        <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      tag1_valid_q  <= 1'b0;
      tag1_owner_q  <= OWNER_A;
      tag2_valid_q  <= 1'b0;
      tag2_owner_q  <= OWNER_A;
    end else begin
      last_winner_q <= last_winner_d;
      m_en_q        <= m_en_d;
      m_we_q        <= m_we_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      tag1_valid_q  <= tag1_valid_d;
      tag1_owner_q  <= tag1_owner_d;
      tag2_valid_q  <= tag2_valid_d;
      tag2_owner_q  <= tag2_owner_d;
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  // Response steering: memory data goes only to the owner of the load.
  always_comb begin
    a_rvalid = tag2_valid_q & (tag2_owner_q == OWNER_A);
    b_rvalid = tag2_valid_q & (tag2_owner_q == OWNER_B);
    a_rdata  = a_rvalid ? m_rdata : '0;
    b_rdata  = b_rvalid ? m_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: drives directed accesses on both ports, models the
// 32-word synchronous-read memory, and checks load responses through a
// scoreboard queue popped by an independent monitor.
module tb_dmem_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ready, a_rvalid, b_ready, b_rvalid, cpu_stall;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  logic [DW-1:0] mem [32];

  // expected responses: {port (0=A,1=B), data}
  logic [DW:0]   sb_q[$];

  int vectors    = 0;
  int miscompares = 0;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .cpu_stall(cpu_stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // memory model: synchronous read, write at the end of the m_en cycle
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pop and compare whenever a response appears
  always @(negedge clk) begin
    logic [DW:0] exp;
    check("rvalid_exclusive", {32'd0, a_rvalid & b_rvalid}, 33'd0);
    if (!a_rvalid) check("a_rdata_idle_zero", {1'b0, a_rdata}, 33'd0);
    if (!b_rvalid) check("b_rdata_idle_zero", {1'b0, b_rdata}, 33'd0);
    if (a_rvalid || b_rvalid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", {b_rvalid, (b_rvalid ? b_rdata : a_rdata)}, 33'h1_FFFF_FFFF);
      end else begin
        exp = sb_q.pop_front();
        $display("rsp port=%s data=%h expected port=%s data=%h",
                 b_rvalid ? "B" : "A", b_rvalid ? b_rdata : a_rdata,
                 exp[DW] ? "B" : "A", exp[DW-1:0]);
        check("response", {b_rvalid, (b_rvalid ? b_rdata : a_rdata)}, exp);
      end
    end
  end

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 | i;
    mem[5] = 32'hDEAD_BEEF;
    m_rdata = '0;
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0;   b_wdata = '0;

    // reset state, with A requesting
    idle(2);
    @(negedge clk);
    check("rst_a_ready", {32'd0, a_ready}, 33'd0);
    check("rst_m_en", {31'd0, m_en, m_we}, 33'd0);
    check("rst_m_addr_wdata", {m_addr[0], m_wdata}, 33'd0);
    step();
    reset = 1'b0;

    // A load addr 5 accepted, then reset while it is in flight
    @(negedge clk);
    check("rst_first_accept", {31'd0, a_ready, cpu_stall}, 33'd2);
    step();
    a_req = 1'b0;
    check("inflight_m_en", {27'd0, m_en, m_addr}, {28'd1, 5'd5});
    #2 reset = 1'b1;
    #1;
    check("async_m_en", {31'd0, m_en, m_we}, 33'd0);
    check("async_m_addr", {28'd0, m_addr}, 33'd0);
    check("async_rvalid", {31'd0, a_rvalid, b_rvalid}, 33'd0);
    idle(2);
    reset = 1'b0;

    // contention straight after reset: A,B,A,B
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("cont_ready_%0d", k), {30'd0, a_ready, b_ready, cpu_stall},
            (k % 2 == 0) ? 33'b100 : 33'b011);
      if (k % 2 == 0) sb_q.push_back({1'b0, 32'h1000_0001});
      else            sb_q.push_back({1'b1, 32'h1000_0002});
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    idle(4);

    // single A load of addr 5
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
    @(negedge clk);
    check("single_ready", {31'd0, a_ready, b_ready}, 33'b10);
    sb_q.push_back({1'b0, 32'hDEAD_BEEF});
    step();
    a_req = 1'b0;
    @(negedge clk);
    check("single_issue", {25'd0, m_en, m_we, m_addr, a_rvalid, b_rvalid}, {25'd0, 1'b1, 1'b0, 5'd5, 2'b00});
    step();
    @(negedge clk);
    check("single_rsp", {a_rvalid, a_rdata}, {1'b1, 32'hDEAD_BEEF});
    check("single_b_quiet", {32'd0, b_rvalid}, 33'd0);
    step();

    // ordering: B stores addr 9, A loads addr 9 next cycle
    b_req = 1'b1; b_we = 1'b1; b_addr = 5'd9; b_wdata = 32'h1234_5678;
    @(negedge clk);
    check("ord_b_ready", {31'd0, a_ready, b_ready}, 33'b01);
    step();
    b_req = 1'b0; b_we = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd9;
    @(negedge clk);
    check("ord_a_ready", {32'd0, a_ready}, 33'd1);
    check("ord_store_issue", {m_we, m_wdata}, {1'b1, 32'h1234_5678});
    sb_q.push_back({1'b0, 32'h1234_5678});
    step();
    a_req = 1'b0;
    idle(1);
    @(negedge clk);
    check("ord_rsp", {a_rvalid, a_rdata}, {1'b1, 32'h1234_5678});
    step();
    idle(2);

    // back-to-back A loads addr 0..7
    a_req = 1'b1; a_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) a_addr = 5'(i);
      else       a_req = 1'b0;
      @(negedge clk);
      if (i < 8) begin
        check($sformatf("b2b_ready_%0d", i), {31'd0, a_ready, cpu_stall}, 33'b10);
        sb_q.push_back({1'b0, (i == 5) ? 32'hDEAD_BEEF : (32'h1000_0000 | i)});
      end
      if (i >= 2) check($sformatf("b2b_rvalid_%0d", i), {32'd0, a_rvalid}, 33'd1);
      step();
    end
    @(negedge clk);
    check("b2b_rvalid_end", {32'd0, a_rvalid}, 33'd0);
    step();
    idle(1);

    // store only: A stores addr 31, then reads it back
    a_req = 1'b1; a_we = 1'b1; a_addr = 5'd31; a_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    check("store_ready", {32'd0, a_ready}, 33'd1);
    step();
    a_req = 1'b0; a_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("store_no_rvalid_%0d", i), {31'd0, a_rvalid, b_rvalid}, 33'd0);
      step();
    end
    a_req = 1'b1; a_addr = 5'd31;
    @(negedge clk);
    sb_q.push_back({1'b0, 32'hA5A5_A5A5});
    step();
    a_req = 1'b0;
    idle(5);

    check("scoreboard_drained", 33'(sb_q.size()), 33'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
